fsqrt_arbiter: RTL and testbench

Shares one pipelined `fsqrt` unit (3-stage, fixed latency, no stall input) among `NREQ` requesters. It grants one requester per cycle using round-robin order. It carries a requester tag alongside each operand and handles IEEE special cases outside the datapath. Results go into an output FIFO with credit-based issue control, so the FPU pipeline never has to stall. The block sits between the FPU issue logic of several clients (core lanes or a vector sequencer) and the shared square-root hardware, which it instantiates internally.

---
 rtl/fsqrt_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_fsqrt_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fsqrt_arbiter.sv
// fsqrt_arbiter: shares one 3-stage pipelined square-root unit among NREQ
// requesters. Round-robin grant (one per cycle), requester tag and IEEE
// special-case bypass travel alongside the datapath, and results are queued
// in a show-ahead FIFO whose occupancy gates issue so the pipe never stalls.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid[i]    requester i has an operand on req_data[32i+31:32i]
//   req_ready[i]    one-hot grant (transfer = req_valid & req_ready)
//   res_valid/ready FIFO head handshake
//   res_data/res_id result and index of the requester that issued it
//   busy            anything in flight or queued

// Fixed-latency square root of positive normal floats. Inputs that are not
// positive normals produce don't-care results and are bypassed by the caller.
// Registers are deliberately not reset.
module fsqrt_unit (
   input  logic        clk,
   input  logic [31:0] a,
   output logic [31:0] s
);
   logic [31:0] a1, r2, r3;
   logic [47:0] rad;
   logic [27:0] rem, trial;
   logic [23:0] root;
   logic [7:0]  exp_h;

   // Odd biased exponent -> even unbiased exponent: radicand is M<<23,
   // otherwise M<<24, so the integer root is always a 24-bit significand.
   always_comb begin
      rad   = {1'b1, a1[22:0], 24'b0} >> a1[23];
      rem   = '0;
      root  = '0;
      trial = '0;
      for (int i = 23; i >= 0; i--) begin
         rem   = {rem[25:0], rad[2*i +: 2]};
         trial = {2'b00, root, 2'b01};
         if (rem >= trial) begin
            rem  = rem - trial;
            root = {root[22:0], 1'b1};
         end else begin
            root = {root[22:0], 1'b0};
         end
      end
      exp_h = 8'(({1'b0, a1[30:23]} + 9'd127) >> 1);
   end

   always_ff @(posedge clk) begin
      a1 <= a;
      r2 <= {a1[31], exp_h, root[23] ? root[22:0] : 23'b0};
      r3 <= r2;
   end

   assign s = r3;
endmodule

module fsqrt_arbiter #(
   parameter int NREQ  = 4,
   parameter int DEPTH = 4,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [32*NREQ-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [31:0]        res_data,
   output logic [IDW-1:0]     res_id,
   output logic               busy
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [IDW-1:0] ptr, gidx;
   logic           grant, credit;
   logic [31:0]    a, a_last, s, bval;
   logic           byp;

   // tag pipeline, index 2 lines up with s
   logic [2:0]     tv;
   logic [IDW-1:0] tid   [3];
   logic           tbyp  [3];
   logic [31:0]    tbval [3];

   logic [CW-1:0]     count;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [32+IDW-1:0] mem [DEPTH];
   logic              push, pop;
   logic [31:0]       push_data;

   // A pop in this cycle is not credited: it frees a slot only next cycle.
   assign credit = (int'(count) + int'(tv[0]) + int'(tv[1]) + int'(tv[2])) < DEPTH;

   always_comb begin
      int j;
      j         = 0;
      grant     = 1'b0;
      gidx      = '0;
      req_ready = '0;
      if (credit && !rst) begin
         for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!grant && req_valid[j]) begin
               grant = 1'b1;
               gidx  = IDW'(j);
            end
         end
      end
      if (grant) req_ready[gidx] = 1'b1;
   end

   // Idle cycles re-present the last operand; their outputs are never tagged.
   assign a = grant ? req_data[int'(gidx)*32 +: 32] : a_last;

   always_comb begin
      byp  = 1'b1;
      bval = '0;
      if (a[30:23] == 8'h00)
         bval = {a[31], 31'b0};
      else if (a[30:23] == 8'hFF && a[22:0] == 23'b0 && !a[31])
         bval = 32'h7F80_0000;
      else if (a[30:23] == 8'hFF || a[31])
         bval = 32'h7FC0_0000;
      else
         byp = 1'b0;
   end

   fsqrt_unit u_fsqrt (.clk(clk), .a(a), .s(s));

   assign push      = tv[2];
   assign push_data = tbyp[2] ? tbval[2] : s;
   assign pop       = res_valid & res_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr    <= '0;
         a_last <= '0;
         tv     <= '0;
         for (int i = 0; i < 3; i++) begin
            tid[i]   <= '0;
            tbyp[i]  <= 1'b0;
            tbval[i] <= '0;
         end
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (grant) begin
            ptr    <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + IDW'(1);
            a_last <= a;
         end
         tv       <= {tv[1:0], grant};
         tid[0]   <= gidx;
         tbyp[0]  <= byp;
         tbval[0] <= bval;
         for (int i = 1; i < 3; i++) begin
            tid[i]   <= tid[i-1];
            tbyp[i]  <= tbyp[i-1];
            tbval[i] <= tbval[i-1];
         end
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage only; validity is tracked by count and pointers.
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {push_data, tid[2]};

   assign res_valid = (count != '0);
   assign res_data  = res_valid ? mem[rd_ptr][32+IDW-1:IDW] : '0;
   assign res_id    = res_valid ? mem[rd_ptr][IDW-1:0] : '0;
   assign busy      = (|tv) | res_valid;
endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Directed bench for fsqrt_arbiter (NREQ=4, DEPTH=4).
module tb_fsqrt_arbiter;
   localparam int NREQ = 4, DEPTH = 4, IDW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid, req_ready;
   logic [32*NREQ-1:0] req_data;
   logic              res_valid, res_ready, busy;
   logic [31:0]       res_data;
   logic [IDW-1:0]    res_id;

   int passed = 0, total = 0;

   always #5 clk = ~clk;

   fsqrt_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_id(res_id), .busy(busy));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operand from requester r and wait (bounded) for its transfer.
   task automatic issue(input int r, input logic [31:0] d);
      int n;
      n = 0;
      req_data[32*r +: 32] = d;
      req_valid = 4'(1 << r);
      #1;
      while (req_ready !== 4'(1 << r) && n < 20) begin
         tick(); #1; n++;
      end
      chk("issue_grant", {28'b0, req_ready}, 32'(1 << r));
      tick();
      req_valid = '0;
   endtask

   // Wait (bounded) for the FIFO head, check it, and pop it.
   task automatic pop(input string tag, input logic [31:0] d, input int id);
      int n;
      n = 0;
      res_ready = 1'b1;
      #1;
      while (res_valid !== 1'b1 && n < 20) begin
         tick(); #1; n++;
      end
      chk({tag, "_v"}, {31'b0, res_valid}, 32'd1);
      chk({tag, "_d"}, res_data, d);
      chk({tag, "_id"}, {30'b0, res_id}, 32'(id));
      tick();
      res_ready = 1'b0;
   endtask

   logic [31:0] rr_in  [4] = '{32'h3F80_0000, 32'h4080_0000, 32'h4110_0000, 32'h4180_0000};
   logic [31:0] rr_res [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
   logic [31:0] bp_in  [5] = '{32'h3F80_0000, 32'h4080_0000, 32'h4110_0000, 32'h4180_0000, 32'h4010_0000};
   logic [31:0] bp_res [5] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h3FC0_0000};

   initial begin
      int gexp, rexp, ngr, nres;
      rst = 1'b1; req_valid = 4'hF; req_data = '0; res_ready = 1'b0;

      // reset state
      tick(); tick();
      chk("rst_ready", {28'b0, req_ready}, 32'd0);
      chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_res_id", {30'b0, res_id}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);

      // single request from requester 2, latency 4
      rst = 1'b0; req_valid = 4'b0100; req_data[64 +: 32] = 32'h4080_0000;
      #1;
      chk("single_grant", {28'b0, req_ready}, 32'h4);
      tick(); req_valid = '0;
      chk("single_busy", {31'b0, busy}, 32'd1);
      tick(); tick();
      chk("single_lat3", {31'b0, res_valid}, 32'd0);
      tick();
      chk("single_lat4", {31'b0, res_valid}, 32'd1);
      pop("single", 32'h4000_0000, 2);
      chk("single_idle", {31'b0, busy}, 32'd0);

      // pointer now 3: requester 3 wins over 0 and 1, then pointer wraps to 0
      req_data[96 +: 32] = 32'h4180_0000; req_data[0 +: 32] = 32'h3F80_0000;
      req_valid = 4'b1011;
      #1;
      chk("ptr3_grant", {28'b0, req_ready}, 32'h8);
      tick(); req_valid = '0;
      pop("ptr3", 32'h4080_0000, 3);

      // all requesters valid, consumer always ready: round-robin order
      for (int i = 0; i < 4; i++) req_data[32*i +: 32] = rr_in[i];
      res_ready = 1'b1;
      gexp = 0; rexp = 0; ngr = 0; nres = 0;
      for (int k = 0; k < 24; k++) begin
         req_valid = (ngr < 12) ? 4'hF : 4'h0;
         #1;
         if (k < 4) chk("rr_back2back", {28'b0, req_ready}, 32'(1 << k));
         if (req_ready != 0) begin
            chk("rr_grant", {28'b0, req_ready}, 32'(1 << gexp));
            gexp = (gexp + 1) % 4; ngr++;
         end
         if (res_valid) begin
            chk("rr_id", {30'b0, res_id}, 32'(rexp));
            chk("rr_data", res_data, rr_res[rexp]);
            rexp = (rexp + 1) % 4; nres++;
         end
         tick();
      end
      req_valid = '0; res_ready = 1'b0;
      chk("rr_ngrant", 32'(ngr), 32'd12);
      chk("rr_nres", 32'(nres), 32'd12);

      // back-pressure: exactly DEPTH transfers, then stall
      req_valid = 4'b0010; req_data[32 +: 32] = bp_in[0];
      for (int k = 0; k < 10; k++) begin
         #1;
         if (k < 4) chk("bp_grant", {28'b0, req_ready}, 32'h2);
         else       chk("bp_stall", {28'b0, req_ready}, 32'h0);
         tick();
         if (k < 4) req_data[32 +: 32] = bp_in[k+1];
      end
      chk("bp_busy", {31'b0, busy}, 32'd1);
      chk("bp_full_valid", {31'b0, res_valid}, 32'd1);
      res_ready = 1'b1;
      #1;
      chk("bp_pop_nocredit", {28'b0, req_ready}, 32'h0);
      chk("bp_head_d", res_data, bp_res[0]);
      chk("bp_head_id", {30'b0, res_id}, 32'd1);
      tick(); res_ready = 1'b0;
      #1;
      chk("bp_resume", {28'b0, req_ready}, 32'h2);
      tick(); req_valid = '0;
      for (int i = 1; i < 5; i++) pop("bp_drain", bp_res[i], 1);

      // special values
      issue(0, 32'h0000_0000); issue(1, 32'h8000_0000);
      issue(2, 32'h7F80_0000); issue(3, 32'hBF80_0000);
      pop("sp_pzero", 32'h0000_0000, 0); pop("sp_nzero", 32'h8000_0000, 1);
      pop("sp_pinf",  32'h7F80_0000, 2); pop("sp_neg",   32'h7FC0_0000, 3);
      issue(0, 32'h7FC0_0001); issue(1, 32'h4000_0000);
      issue(2, 32'hFF80_0000); issue(3, 32'h0000_0001);
      pop("sp_nan",   32'h7FC0_0000, 0); pop("sp_sqrt2", 32'h3FB5_04F3, 1);
      pop("sp_ninf",  32'h7FC0_0000, 2); pop("sp_denorm", 32'h0000_0000, 3);

      // reset with results both in flight and queued
      issue(0, 32'h3F80_0000); issue(1, 32'h4080_0000);
      issue(2, 32'h4110_0000); issue(3, 32'h4180_0000);
      tick();
      chk("mid_pre_valid", {31'b0, res_valid}, 32'd1);
      rst = 1'b1; req_valid = 4'b1000;
      #1;
      chk("mid_rst_valid", {31'b0, res_valid}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_ready", {28'b0, req_ready}, 32'h0);
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_grant", {28'b0, req_ready}, 32'h8);
      tick(); req_valid = '0;
      for (int k = 0; k < 3; k++) begin
         chk("post_rst_quiet", {31'b0, res_valid}, 32'd0);
         tick();
      end
      chk("post_rst_lat4", {31'b0, res_valid}, 32'd1);
      pop("post_rst", 32'h4080_0000, 3);

      // pointer wrapped from 3 back to 0
      req_data[0 +: 32] = 32'h4010_0000;
      req_valid = 4'b1011;
      #1;
      chk("wrap_grant", {28'b0, req_ready}, 32'h1);
      tick(); req_valid = '0;
      pop("wrap", 32'h3FC0_0000, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
